// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding valid/ready data-memory responder with a fixed LAT-cycle
// response latency. Define DMEM_INIT_EN to zero the whole array after every reset.
module dmem_responder #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LAT    = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_we,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy
);

   localparam int unsigned Depth   = 2 ** ADDR_W;
   localparam logic [3:0]  LatInit = 4'(LAT - 1);

   if (LAT < 1 || LAT > 15) begin : g_lat_check
      $error("dmem_responder: LAT must be in 1..15");
   end

`ifdef DMEM_INIT_EN
   typedef enum logic [1:0] {StIdle, StWait, StResp, StInit} state_e;
   localparam state_e StReset = StInit;
`else
   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;
   localparam state_e StReset = StIdle;
`endif

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                rsp_we_q, rsp_we_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic [DATA_W-1:0]   mem [Depth];
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_waddr;
   logic [DATA_W-1:0]   mem_wdata;
   logic                accept;

`ifdef DMEM_INIT_EN
   logic [ADDR_W-1:0]   sweep_q, sweep_d;
`endif

   assign accept = (state_q == StIdle) && req_valid;

   // State register and response holding registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StReset;
         cnt_q       <= '0;
         rsp_we_q    <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rsp_we_q    <= rsp_we_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

`ifdef DMEM_INIT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sweep_q <= '0;
      end else begin
         sweep_q <= sweep_d;
      end
   end

   always_comb begin
      sweep_d = sweep_q;
      if (state_q == StInit) begin
         sweep_d = sweep_q + ADDR_W'(1);
      end
   end
`endif

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               cnt_d   = LatInit;
               state_d = (LAT == 1) ? StResp : StWait;
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = StResp;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
`ifdef DMEM_INIT_EN
         StInit: begin
            if (sweep_q == '1) begin
               state_d = StIdle;
            end
         end
`endif
         default: state_d = StReset;
      endcase
   end

   // Load data is taken from the pre-edge array contents; stores answer with zero.
   always_comb begin
      rsp_we_d    = rsp_we_q;
      rsp_rdata_d = rsp_rdata_q;
      if (accept) begin
         rsp_we_d    = req_we;
         rsp_rdata_d = req_we ? '0 : mem[req_addr];
      end
   end

   always_comb begin
      mem_we    = accept && req_we;
      mem_waddr = req_addr;
      mem_wdata = req_wdata;
`ifdef DMEM_INIT_EN
      if (state_q == StInit) begin
         mem_we    = 1'b1;
         mem_waddr = sweep_q;
         mem_wdata = '0;
      end
`endif
   end

   // Storage is deliberately not reset so accepted stores survive a reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // Output logic.
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b1;
      unique case (state_q)
         StIdle: begin
            req_ready = 1'b1;
            busy      = 1'b0;
         end
         StResp:  rsp_valid = 1'b1;
         default: ;
      endcase
      rsp_we    = rsp_we_q;
      rsp_rdata = rsp_rdata_q;
   end

endmodule
